lfsr_stream_checker: RTL and testbench

Self-synchronising checker for the pseudo-random bit streams produced by the team's LFSR generator banks. It seeds a local history from the first WIDTH received bits, then predicts each following bit from the LFSR recurrence and reports mismatches. It sits at the consuming end of an LFSR-driven stream (after a digit serialiser or an online-arithmetic datapath under test) and gives a pass/fail and error-count verdict without needing the generator's preset.

---
 rtl/lfsr_stream_checker.sv | 116 +++++++++++
 tb/tb_lfsr_stream_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising LFSR stream checker: seeds its history from the received
// stream, then predicts each bit from the recurrence and counts mismatches.
module lfsr_stream_checker #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] TAPS        = 32'hE000_0200,
    parameter int               LOSS_THRESH = 8,
    parameter int               CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic             o_lock_lost,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_checked_count
);

    localparam int            FW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
    localparam logic [7:0]    THRESH    = 8'(LOSS_THRESH);

    typedef enum logic {ST_SEED, ST_CHECK} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic [7:0]       r_consec;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_lock_lost;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_checked_count;

    logic [WIDTH-1:0] w_hist_nxt;
    logic             w_pred;
    logic             w_mis;
    logic [7:0]       w_consec_inc;
    logic [CNT_W-1:0] w_err_sat;
    logic [CNT_W-1:0] w_chk_sat;

    // Received bits always enter the history, errors included, so the
    // checker resynchronises by itself after a corrupted beat.
    assign w_hist_nxt   = {r_hist[WIDTH-2:0], i_bit};
    assign w_pred       = ^(r_hist & TAPS);
    assign w_mis        = (i_bit != w_pred);
    assign w_consec_inc = r_consec + 8'd1;
    assign w_err_sat    = (&r_err_count) ? r_err_count : r_err_count + CNT_W'(1);
    assign w_chk_sat    = (&r_checked_count) ? r_checked_count : r_checked_count + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_SEED;
            r_hist          <= '0;
            r_fill          <= '0;
            r_consec        <= '0;
            r_locked        <= 1'b0;
            r_err_pulse     <= 1'b0;
            r_lock_lost     <= 1'b0;
            r_err_count     <= '0;
            r_checked_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
            if (i_valid) begin
                r_hist <= w_hist_nxt;
                case (r_state)
                    ST_SEED: begin
                        if (r_fill == FILL_LAST) begin
                            r_fill <= '0;
                            // An all-zero history is a dead LFSR state; reseed.
                            if (|w_hist_nxt) begin
                                r_state  <= ST_CHECK;
                                r_locked <= 1'b1;
                                r_consec <= '0;
                            end
                        end else begin
                            r_fill <= r_fill + FW'(1);
                        end
                    end
                    ST_CHECK: begin
                        r_checked_count <= w_chk_sat;
                        if (w_mis) begin
                            r_err_pulse <= 1'b1;
                            r_err_count <= w_err_sat;
                            if (w_consec_inc == THRESH) begin
                                r_state     <= ST_SEED;
                                r_locked    <= 1'b0;
                                r_fill      <= '0;
                                r_consec    <= '0;
                                r_lock_lost <= 1'b1;
                            end else begin
                                r_consec <= w_consec_inc;
                            end
                        end else begin
                            r_consec <= '0;
                        end
                    end
                endcase
            end
            if (i_clear) begin
                r_err_count     <= '0;
                r_checked_count <= '0;
            end
        end
    end

    assign o_locked        = r_locked;
    assign o_err_pulse     = r_err_pulse;
    assign o_lock_lost     = r_lock_lost;
    assign o_err_count     = r_err_count;
    assign o_checked_count = r_checked_count;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomised bench for lfsr_stream_checker: two instances (16-bit and 4-bit
// counters) share one stimulus and are compared every cycle to a bit-list model.
module tb_lfsr_stream_checker;

    localparam logic [31:0] TAPS_C = 32'hE000_0200;
    localparam int          NW     = 32;
    localparam int          LOSS   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, bit_in, clear;
    logic        locked, err_pulse, lock_lost;
    logic [15:0] err_count, checked_count;
    logic        locked4, err_pulse4, lock_lost4;
    logic [3:0]  err_count4, checked_count4;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: list of received bits since reset plus lock bookkeeping.
    bit     m_bits[$];
    bit     m_locked, m_errp, m_lost;
    int     m_fill, m_consec;
    longint m_err, m_chk;
    logic [31:0] g;

    always #5 clk = ~clk;

    lfsr_stream_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_bit(bit_in), .i_clear(clear),
        .o_locked(locked), .o_err_pulse(err_pulse), .o_lock_lost(lock_lost),
        .o_err_count(err_count), .o_checked_count(checked_count)
    );

    lfsr_stream_checker #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_bit(bit_in), .i_clear(clear),
        .o_locked(locked4), .o_err_pulse(err_pulse4), .o_lock_lost(lock_lost4),
        .o_err_count(err_count4), .o_checked_count(checked_count4)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit model_pred();
        logic [31:0] taps_v;
        bit p;
        int idx;
        taps_v = TAPS_C;
        p = 1'b0;
        for (int k = 0; k < NW; k++) begin
            idx = m_bits.size() - 1 - k;
            if (taps_v[k] && idx >= 0) p ^= m_bits[idx];
        end
        return p;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_locked = 0; m_errp = 0; m_lost = 0;
        m_fill = 0; m_consec = 0; m_err = 0; m_chk = 0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit clr);
        bit pred, any;
        m_errp = 0;
        m_lost = 0;
        if (v) begin
            pred = model_pred();
            m_bits.push_back(b);
            if (m_bits.size() > 2 * NW) void'(m_bits.pop_front());
            if (m_locked) begin
                m_chk++;
                if (b != pred) begin
                    m_errp = 1;
                    m_err++;
                    m_consec++;
                    if (m_consec == LOSS) begin
                        m_locked = 0; m_consec = 0; m_fill = 0; m_lost = 1;
                    end
                end else begin
                    m_consec = 0;
                end
            end else begin
                m_fill++;
                if (m_fill == NW) begin
                    m_fill = 0;
                    any = 0;
                    for (int k = 0; k < NW; k++) any |= m_bits[m_bits.size() - 1 - k];
                    if (any) begin
                        m_locked = 1;
                        m_consec = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_err = 0;
            m_chk = 0;
        end
    endtask

    task automatic compare_all();
        check("locked",     locked,         m_locked);
        check("err_pulse",  err_pulse,      m_errp);
        check("lock_lost",  lock_lost,      m_lost);
        check("err_count",  err_count,      sat(m_err, 16));
        check("chk_count",  checked_count,  sat(m_chk, 16));
        check("locked4",    locked4,        m_locked);
        check("err_pulse4", err_pulse4,     m_errp);
        check("lock_lost4", lock_lost4,     m_lost);
        check("err_count4", err_count4,     sat(m_err, 4));
        check("chk_count4", checked_count4, sat(m_chk, 4));
    endtask

    task automatic beat(input bit v, input bit b, input bit clr);
        @(negedge clk);
        valid = v; bit_in = b; clear = clr;
        @(posedge clk);
        model_edge(v, b, clr);
        #1 compare_all();
    endtask

    task automatic gen_next(output bit nb);
        nb = ^(g & TAPS_C);
        g = {g[30:0], nb};
    endtask

    task automatic send_gen(input bit flip, input bit clr);
        bit b;
        gen_next(b);
        beat(1'b1, b ^ flip, clr);
    endtask

    task automatic idle(input bit clr);
        beat(1'b0, 1'($urandom), clr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0; valid = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [63:0] seen;
    localparam logic [63:0] FLIP_OFFS = 64'h1_C000_0401;

    initial begin
        rst_n = 1'b0; valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        g = $urandom;
        if (g == 0) g = 32'h1;
        model_reset();
        #12 compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream at full rate
        for (int i = 0; i < 1032; i++) begin
            send_gen(1'b0, 1'b0);
            if (i == 30) check("not_locked_31", locked, 0);
            if (i == 31) check("locked_32", locked, 1);
        end
        check("clean_chk", checked_count, 1000);
        check("clean_err", err_count, 0);

        // Single flipped bit
        idle(1'b1);
        seen = '0;
        for (int i = 0; i < 41; i++) begin
            send_gen(i == 0, 1'b0);
            if (err_pulse) seen[i] = 1'b1;
        end
        check("flip_offsets", seen, FLIP_OFFS);
        check("flip_err", err_count, 5);
        check("flip_locked", locked, 1);

        // Loss of lock: drive the inverse of the prediction
        idle(1'b1);
        for (int i = 0; i < LOSS; i++) beat(1'b1, ~model_pred(), 1'b0);
        check("loss_pulse", lock_lost, 1);
        check("loss_locked", locked, 0);
        check("loss_err", err_count, 8);
        for (int i = 0; i < NW; i++) send_gen(1'b0, 1'b0);
        check("relock", locked, 1);

        // Saturation of the 4-bit counters: four isolated flips, 20 mismatches
        idle(1'b1);
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 45; i++) send_gen(i == 0, 1'b0);
        check("sat_err4", err_count4, 15);
        check("sat_err16", err_count, 20);

        // Clear coinciding with a mismatching beat
        beat(1'b1, ~model_pred(), 1'b1);
        check("clr_err", err_count, 0);
        check("clr_pulse", err_pulse, 1);
        for (int i = 0; i < 40; i++) send_gen(1'b0, 1'($urandom_range(0, 15) == 0));

        // Reset in the middle of seeding
        do_reset();
        for (int i = 0; i < 20; i++) send_gen(1'b0, 1'b0);
        do_reset();
        check("rst_locked", locked, 0);
        for (int i = 0; i < NW; i++) begin
            send_gen(1'b0, 1'b0);
            if (i == NW - 2) check("rst_not_locked_31", locked, 0);
        end
        check("rst_relock", locked, 1);

        // All-zero seed
        do_reset();
        for (int i = 0; i < NW; i++) beat(1'b1, 1'b0, 1'b0);
        check("zero_seed_locked", locked, 0);
        for (int i = 0; i < NW; i++) send_gen(1'b0, 1'b0);
        check("zero_then_locked", locked, 1);
        for (int i = 0; i < 20; i++) send_gen(1'b0, 1'b0);
        check("zero_then_err", err_count, 0);

        // Clean stream with random gaps
        do_reset();
        for (int i = 0; i < 1032; i++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) idle(1'b0);
            send_gen(1'b0, 1'b0);
        end
        check("gap_chk", checked_count, 1000);
        check("gap_err", err_count, 0);
        check("gap_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
